// File: rtl/button_debounce.sv
// button_debounce: per-button 2-flop synchroniser and debounce counter with registered rise/fall pulses.
// Define BTN_STICKY_EN to build the sticky "pressed since last clear" register.
module button_debounce #(
  parameter int N_BTN           = 8,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 15
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_stable,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  input  logic [N_BTN-1:0] sticky_clr,
  output logic [N_BTN-1:0] press_sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [CNT_W-1:0] cnt [N_BTN];

  // NOTE: every flop here is written with <= so all bits see the pre-edge values of each other.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // NOTE: the counter array is cleared on reset on purpose, so a reset mid-count cannot leave a stale count behind.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      btn_stable <= '0;
      btn_rise   <= '0;
      btn_fall   <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      btn_rise <= '0;
      btn_fall <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] == btn_stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          btn_stable[i] <= sync2[i];
          btn_rise[i]   <= sync2[i];
          btn_fall[i]   <= ~sync2[i];
          cnt[i]        <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef BTN_STICKY_EN
  // A press arriving in the same cycle as its clear wins, so no press is lost.
  always_ff @(posedge clk) begin
    if (!rstn) press_sticky <= '0;
    else       press_sticky <= btn_rise | (press_sticky & ~sticky_clr);
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = ^sticky_clr;
  assign press_sticky      = '0;
`endif

endmodule
